// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
// BOOTH_UNSIGNED_EN widens the multiplier register by one bit for zero-extended operands.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } booth_op_e;

    // {Q[0], q_m1} pairs that need an accumulator update; 00 and 11 are NOP
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

    function automatic int q_width(input int width);
`ifdef BOOTH_UNSIGNED_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        case (pair)
            PAIR_ADD: return OP_ADD;
            PAIR_SUB: return OP_SUB;
            default:  return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One combinational Booth iteration: decode {Q[0],q_m1}, add/sub M into A, arithmetic shift.
// Latency: none (pure combinational); backpressure: n/a.
module booth_radix2_step
    import booth_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int QW    = q_width(WIDTH)
)
(
    input  logic [WIDTH:0]  a,
    input  logic [QW-1:0]   q,
    input  logic            q_m1,
    input  logic [WIDTH:0]  m,
    output logic [WIDTH:0]  a_nxt,
    output logic [QW-1:0]   q_nxt,
    output logic            q_m1_nxt
);

    booth_op_e      op;
    logic [WIDTH:0] sum;

    always_comb begin
        op  = booth_decode({q[0], q_m1});
        sum = a;
        case (op)
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
    end

    assign a_nxt    = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt    = {sum[0], q[QW-1:1]};
    assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one iteration per clock; BOOTH_UNSIGNED_EN adds is_signed.
// Latency: N+1 edges from accepting start to done (N = WIDTH, or WIDTH+1 with BOOTH_UNSIGNED_EN).
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 is_signed,
`endif
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int             QW       = q_width(WIDTH);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  N_ITER   = CW'(QW);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [QW-1:0]        q_q, q_d;
    logic                 q_m1_q, q_m1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       m_load;
    logic [QW-1:0]        q_load;
    logic [WIDTH:0]       a_nxt;
    logic [QW-1:0]        q_nxt;
    logic                 q_m1_nxt;
    logic [2*WIDTH-1:0]   product_nxt;

    // The extra accumulator bit lets M = -2^(WIDTH-1) be negated exactly
`ifdef BOOTH_UNSIGNED_EN
    assign m_load      = {is_signed & multiplicand[WIDTH-1], multiplicand};
    assign q_load      = {is_signed & multiplier[WIDTH-1], multiplier};
    assign product_nxt = {a_nxt[WIDTH-2:0], q_nxt};
`else
    assign m_load      = {multiplicand[WIDTH-1], multiplicand};
    assign q_load      = multiplier;
    assign product_nxt = {a_nxt[WIDTH-1:0], q_nxt};
`endif

    booth_radix2_step #(.WIDTH(WIDTH)) u_step (
        .a        (a_q),
        .q        (q_q),
        .q_m1     (q_m1_q),
        .m        (m_q),
        .a_nxt    (a_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = q_load;
                    q_m1_d  = 1'b0;
                    m_d     = m_load;
                    cnt_d   = N_ITER;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_nxt;
                q_d    = q_nxt;
                q_m1_d = q_m1_nxt;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    product_d = product_nxt;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier at WIDTH=8 with hand-computed products.
module tb_booth_seq_multiplier;

    localparam int WIDTH = 8;
`ifdef BOOTH_UNSIGNED_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  multiplicand = '0;
    logic [WIDTH-1:0]  multiplier = '0;
`ifdef BOOTH_UNSIGNED_EN
    logic              is_signed = 1'b1;
`endif
    logic [2*WIDTH-1:0] product;
    logic              busy;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
`ifdef BOOTH_UNSIGNED_EN
        .is_signed    (is_signed),
`endif
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 64) begin
            step();
            cycles++;
        end
    endtask

    task automatic op_run(input string tag, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp);
        int c;
        int nb;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "/busy0"}, busy, 1);
        nb = 1;
        c  = 0;
        while (!done && c < 64) begin
            step();
            c++;
            if (busy) nb++;
        end
        chk({tag, "/lat"}, c, N);
        chk({tag, "/busy_cycles"}, nb, N);
        chk({tag, "/done"}, done, 1);
        chk({tag, "/prod"}, product, exp);
        step();
        chk({tag, "/done_pulse"}, done, 0);
        chk({tag, "/idle"}, busy, 0);
        chk({tag, "/hold"}, product, exp);
    endtask

    initial begin
        int c;
        int ndone;
        logic [15:0] seen;

        step();
        step();
        chk("rst/product", product, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        reset = 1'b0;
        step();
        chk("idle/busy", busy, 0);

        op_run("3x-5",      8'd3,   8'hFB, 16'hFFF1);
        op_run("-128x-128", 8'h80,  8'h80, 16'h4000);
        op_run("-128x127",  8'h80,  8'h7F, 16'hC080);
        op_run("127x127",   8'h7F,  8'h7F, 16'h3F01);
        op_run("-1x1",      8'hFF,  8'h01, 16'hFFFF);
        op_run("0x-77",     8'h00,  8'hB3, 16'h0000);

        // back-to-back: start held high through DONE
        multiplicand = 8'd7;
        multiplier   = 8'd6;
        start        = 1'b1;
        step();
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        wait_done(c);
        chk("b2b/lat1", c, N);
        chk("b2b/prod1", product, 16'h002A);
        step();
        chk("b2b/nogap", busy, 1);
        wait_done(c);
        chk("b2b/spacing", c + 1, N + 1);
        chk("b2b/prod2", product, 16'h0001);
        start = 1'b0;
        step();
        chk("b2b/idle", busy, 0);
        chk("b2b/done_drop", done, 0);

        // reset in the middle of a run
        multiplicand = 8'd3;
        multiplier   = 8'hFB;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst/busy", busy, 0);
        chk("midrst/done", done, 0);
        chk("midrst/product", product, 0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) ndone++;
        end
        chk("midrst/no_done", ndone, 0);
        chk("midrst/product_after", product, 0);

        // start pulses during RUN must be ignored
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
        start        = 1'b1;
        step();
        step();
        start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                ndone++;
                seen = product;
            end
        end
        chk("ignore/ops", ndone, 1);
        chk("ignore/prod", seen, 16'h0051);

`ifdef BOOTH_UNSIGNED_EN
        is_signed = 1'b0;
        op_run("u255x255", 8'hFF, 8'hFF, 16'hFE01);
        is_signed = 1'b1;
        op_run("s255x255", 8'hFF, 8'hFF, 16'h0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
